// File: rtl/calc_pkg.sv
// Shared calculator definitions: entry-state encoding, operand sizing and BCD-to-binary conversion.
package calc_pkg;

    localparam int OPERAND_W  = 14;
    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        READY   = 2'd2
    } entry_state_e;

    // d3*1000 + d2*100 + d1*10 + d0 using shifts and adds only; 9999 fits in 14 bits
    function automatic logic [OPERAND_W-1:0] bcd2bin(input logic [4*NUM_DIGITS-1:0] bcd);
        logic [OPERAND_W-1:0] d3, d2, d1, d0;
        d3 = OPERAND_W'(bcd[15:12]);
        d2 = OPERAND_W'(bcd[11:8]);
        d1 = OPERAND_W'(bcd[7:4]);
        d0 = OPERAND_W'(bcd[3:0]);
        return (d3 << 10) - (d3 << 4) - (d3 << 3)
             + (d2 << 6) + (d2 << 5) + (d2 << 2)
             + (d1 << 3) + (d1 << 1)
             + d0;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchroniser, stability counter, registered press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1, sync2, level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Accept the new level; only a rising level counts as a press
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Operand entry controller: five debounced buttons edit a 4-digit BCD buffer and commit A, then B.
module operand_entry
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 btnU,
    input  logic                 btnD,
    input  logic                 btnL,
    input  logic                 btnR,
    input  logic                 btnC,
    output logic [15:0]          digits,
    output logic [1:0]           cursor,
    output logic [OPERAND_W-1:0] operand_a,
    output logic [OPERAND_W-1:0] operand_b,
    output logic                 operands_valid,
    output logic [1:0]           entry_state
);
    logic [4:0]                 press;
    logic                       pressC, pressU, pressD, pressL, pressR;
    logic [NUM_DIGITS-1:0][3:0] digBuf;
    logic [3:0]                 curDigit;
    entry_state_e               state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebounce [4:0] (
        .clk   (CLK100MHZ),
        .rst   (rst),
        .raw   ({btnC, btnU, btnD, btnL, btnR}),
        .press (press)
    );

    assign {pressC, pressU, pressD, pressL, pressR} = press;
    assign curDigit    = digBuf[cursor];
    assign digits      = digBuf;
    assign entry_state = state;

    // if/else order encodes priority C > U > D > L > R
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state          <= ENTER_A;
            digBuf         <= '0;
            cursor         <= 2'd0;
            operand_a      <= '0;
            operand_b      <= '0;
            operands_valid <= 1'b0;
        end else if (pressC) begin
            digBuf <= '0;
            cursor <= 2'd0;
            case (state)
                ENTER_A: begin
                    operand_a <= bcd2bin(digBuf);
                    state     <= ENTER_B;
                end
                ENTER_B: begin
                    operand_b      <= bcd2bin(digBuf);
                    operands_valid <= 1'b1;
                    state          <= READY;
                end
                default: begin
                    operands_valid <= 1'b0;
                    state          <= ENTER_A;
                end
            endcase
        end else if (state == ENTER_A || state == ENTER_B) begin
            if (pressU)
                digBuf[cursor] <= (curDigit == 4'd9) ? 4'd0 : curDigit + 4'd1;
            else if (pressD)
                digBuf[cursor] <= (curDigit == 4'd0) ? 4'd9 : curDigit - 4'd1;
            else if (pressL)
                cursor <= cursor + 2'd1;
            else if (pressR)
                cursor <= cursor - 2'd1;
        end
    end

endmodule

// File: tb/tb_operand_entry.sv
// Directed vector bench for operand_entry with a short debounce window.
`timescale 1ns/100ps
module tb_operand_entry;
    localparam int DB = 8;

    localparam logic [4:0] BC = 5'b10000;
    localparam logic [4:0] BU = 5'b01000;
    localparam logic [4:0] BD = 5'b00100;
    localparam logic [4:0] BL = 5'b00010;
    localparam logic [4:0] BR = 5'b00001;

    logic        clk = 1'b0;
    logic        rst;
    logic        btnU, btnD, btnL, btnR, btnC;
    logic [15:0] digits;
    logic [1:0]  cursor;
    logic [13:0] operand_a, operand_b;
    logic        operands_valid;
    logic [1:0]  entry_state;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        string       name;
        logic [4:0]  btns;
        int          rep;
        logic [15:0] expDigits;
        logic [1:0]  expCursor;
        logic [1:0]  expState;
        logic [13:0] expA;
        logic [13:0] expB;
        logic        expValid;
    } vec_t;

    vec_t vecs[24];
    int   nVecs;

    always #5 clk = ~clk;

    operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLK100MHZ      (clk),
        .rst            (rst),
        .btnU           (btnU),
        .btnD           (btnD),
        .btnL           (btnL),
        .btnR           (btnR),
        .btnC           (btnC),
        .digits         (digits),
        .cursor         (cursor),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .operands_valid (operands_valid),
        .entry_state    (entry_state)
    );

    function automatic logic [48:0] outs();
        return {digits, cursor, entry_state, operand_a, operand_b, operands_valid};
    endfunction

    task automatic check(input string name, input logic [48:0] act, input logic [48:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got dig=%h cur=%0d st=%0d A=%0d B=%0d v=%0d, want dig=%h cur=%0d st=%0d A=%0d B=%0d v=%0d",
                     name, act[48:33], act[32:31], act[30:29], act[28:15], act[14:1], act[0],
                     exp[48:33], exp[32:31], exp[30:29], exp[28:15], exp[14:1], exp[0]);
        end
    endtask

    task automatic setBtns(input logic [4:0] m);
        {btnC, btnU, btnD, btnL, btnR} = m;
    endtask

    // Clean press and release, each held long enough to debounce fully
    task automatic pressBtns(input logic [4:0] m);
        @(negedge clk);
        setBtns(m);
        repeat (DB + 4) @(negedge clk);
        setBtns(5'b0);
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic addVec(input string n, input logic [4:0] b, input int r, input logic [15:0] d,
                          input logic [1:0] c, input logic [1:0] s, input logic [13:0] a,
                          input logic [13:0] bb, input logic v);
        vecs[nVecs] = '{n, b, r, d, c, s, a, bb, v};
        nVecs++;
    endtask

    initial begin
        nVecs = 0;
        // Entry sequence
        addVec("entry_U1",   BU,      1, 16'h0001, 2'd1 - 2'd1, 2'd0, 14'd0,  14'd0,  1'b0);
        addVec("entry_L1",   BL,      1, 16'h0001, 2'd1, 2'd0, 14'd0,  14'd0,  1'b0);
        addVec("entry_U2",   BU,      1, 16'h0011, 2'd1, 2'd0, 14'd0,  14'd0,  1'b0);
        addVec("commit_A",   BC,      1, 16'h0000, 2'd0, 2'd1, 14'd11, 14'd0,  1'b0);
        addVec("entry_L2",   BL,      1, 16'h0000, 2'd1, 2'd1, 14'd11, 14'd0,  1'b0);
        addVec("entry_U3",   BU,      1, 16'h0010, 2'd1, 2'd1, 14'd11, 14'd0,  1'b0);
        addVec("commit_B",   BC,      1, 16'h0000, 2'd0, 2'd2, 14'd11, 14'd10, 1'b1);
        // READY ignores edits, C returns to entry keeping operands
        addVec("ready_U",    BU,      1, 16'h0000, 2'd0, 2'd2, 14'd11, 14'd10, 1'b1);
        addVec("ready_D",    BD,      1, 16'h0000, 2'd0, 2'd2, 14'd11, 14'd10, 1'b1);
        addVec("ready_L",    BL,      1, 16'h0000, 2'd0, 2'd2, 14'd11, 14'd10, 1'b1);
        addVec("ready_R",    BR,      1, 16'h0000, 2'd0, 2'd2, 14'd11, 14'd10, 1'b1);
        addVec("ready_C",    BC,      1, 16'h0000, 2'd0, 2'd0, 14'd11, 14'd10, 1'b0);
        // Wrap-around
        addVec("wrap_10U",   BU,     10, 16'h0000, 2'd0, 2'd0, 14'd11, 14'd10, 1'b0);
        addVec("wrap_D",     BD,      1, 16'h0009, 2'd0, 2'd0, 14'd11, 14'd10, 1'b0);
        addVec("wrap_R",     BR,      1, 16'h0009, 2'd3, 2'd0, 14'd11, 14'd10, 1'b0);
        addVec("wrap_U",     BU,      1, 16'h1009, 2'd3, 2'd0, 14'd11, 14'd10, 1'b0);
        // Simultaneous presses
        addVec("simul_UL",   BU | BL, 1, 16'h2009, 2'd3, 2'd0, 14'd11, 14'd10, 1'b0);
        addVec("simul_CD",   BC | BD, 1, 16'h0000, 2'd0, 2'd1, 14'd2009, 14'd10, 1'b0);
        // Build 0042 in ENTER_B for the reset test
        addVec("build_U2",   BU,      2, 16'h0002, 2'd0, 2'd1, 14'd2009, 14'd10, 1'b0);
        addVec("build_L",    BL,      1, 16'h0002, 2'd1, 2'd1, 14'd2009, 14'd10, 1'b0);
        addVec("build_U4",   BU,      4, 16'h0042, 2'd1, 2'd1, 14'd2009, 14'd10, 1'b0);
    end

    initial begin
        rst = 1'b1;
        setBtns(5'b0);
        repeat (3) @(negedge clk);
        check("reset_state", outs(), 49'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < nVecs; i++) begin
            for (int r = 0; r < vecs[i].rep; r++) pressBtns(vecs[i].btns);
            check(vecs[i].name, outs(),
                  {vecs[i].expDigits, vecs[i].expCursor, vecs[i].expState,
                   vecs[i].expA, vecs[i].expB, vecs[i].expValid});
        end

        // Asynchronous reset mid-entry, mid-cycle
        @(posedge clk);
        #2;
        rst = 1'b1;
        #0.5;
        check("reset_async", outs(), 49'd0);
        #0.5;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_after", outs(), 49'd0);

        // Bounce: glitches then a clean hold give one increment at a fixed latency
        @(negedge clk);
        btnU = 1'b1; repeat (5) @(negedge clk);
        btnU = 1'b0; repeat (2) @(negedge clk);
        btnU = 1'b1; repeat (2) @(negedge clk);
        btnU = 1'b0; repeat (2) @(negedge clk);
        check("bounce_glitch", outs(), 49'd0);
        btnU = 1'b1;
        repeat (DB + 2) @(posedge clk);
        #1;
        check("bounce_before", outs(), 49'd0);
        @(posedge clk);
        #1;
        check("bounce_event", outs(), {16'h0001, 2'd0, 2'd0, 14'd0, 14'd0, 1'b0});
        repeat (3 * DB) @(negedge clk);
        btnU = 1'b0;
        repeat (3 * DB) @(negedge clk);
        check("bounce_single", outs(), {16'h0001, 2'd0, 2'd0, 14'd0, 14'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
# operand_entry

Front-panel operand entry controller for the calculator. It debounces the five push-buttons and turns presses into edits of a 4-digit decimal entry buffer, with a cursor selecting the digit being edited. Centre presses commit the buffer as operand A, then operand B, then return to entry. It sits between the raw button pins and the arithmetic/display logic in `top`, and supplies BCD digits and a cursor to the seven-segment driver and binary operands to the ALU.

## Interface
- `DEBOUNCE_CYCLES`, default 50_000: number of consecutive stable samples needed to accept a button level change (0.5 ms at 100 MHz). Minimum 2.
- `CLK100MHZ`  in  1: system clock, 100 MHz.
- `rst`  in  1: reset, asynchronous, active-high; driven from `sw[0]` in `top`.
- `btnU` / `btnD` / `btnL` / `btnR` / `btnC`  in  1 each: raw, asynchronous, bouncing push-buttons.
- `digits`  out  16: BCD entry buffer; digit 3 at [15:12], digit 0 at [3:0].
- `cursor`  out  2: index of the digit being edited; 0 is the rightmost digit.
- `operand_a`  out  14: committed operand A, binary, range 0..9999.
- `operand_b`  out  14: committed operand B, binary, range 0..9999.
- `operands_valid`  out  1: high while both operands are committed (state READY).
- `entry_state`  out  2: ENTER_A = 2'd0, ENTER_B = 2'd1, READY = 2'd2; drives `LED[1:0]`.

## Operation
- **Per-button front end.**
  - 2-FF synchroniser feeds a debounce counter.
  - The counter clears whenever the synced input equals the debounced level, and increments while they differ.
  - On reaching DEBOUNCE_CYCLES−1 while still differing, the debounced level flips and the counter clears.
  - A press event is a 1-cycle pulse on the rising edge of the debounced level. Releases generate no event.
- **Event priority within one cycle:** C > U > D > L > R. At most one event is acted on per cycle; lower-priority events in the same cycle are discarded.
- **Edits** (ENTER_A and ENTER_B only):
  - U: `digits[cursor]` +1, with 9→0 wrap.
  - D: `digits[cursor]` −1, with 0→9 wrap.
  - L: cursor +1, with 3→0 wrap.
  - R: cursor −1, with 0→3 wrap.
- **Centre button (C) and state transitions:**
  - ENTER_A + C: `operand_a` ← bin(digits); digits ← 0; cursor ← 0; go to ENTER_B.
  - ENTER_B + C: `operand_b` ← bin(digits); digits ← 0; cursor ← 0; go to READY.
  - READY + C: digits ← 0; cursor ← 0; go to ENTER_A. `operand_a` and `operand_b` keep their values.
  - READY + U/D/L/R: ignored; no change to any output.
- **Binary conversion:** bin = d3·1000 + d2·100 + d1·10 + d0.
  - Computed combinationally in 14 bits using shift-adds only (no multiplier instance).
  - Registered at commit.
  - Maximum value 9999 < 2^14, so no overflow is possible.
- **Reset values:** all outputs 0; state ENTER_A; debounced levels 0; counters 0.
- **Reset asserted mid-operation:** aborts immediately and asynchronously to the above values.
- **Buttons held through reset release:** a button already high when `rst` deasserts produces one press event once it has been stable for DEBOUNCE_CYCLES. This is intended.

## Timing
- **Raw button rise to event pulse:** exactly DEBOUNCE_CYCLES+2 rising edges, provided the input is clean. The effect is visible on `digits`, `cursor`, `entry_state` or the operands on the next edge.
- **Glitch rejection:** a high or low pulse shorter than DEBOUNCE_CYCLES−1 cycles (after synchronisation) never changes the debounced level.
- **`operands_valid`:** rises on the same edge that `operand_b` loads, and falls on the edge that leaves READY.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- No backpressure: the consumer samples the operands while `operands_valid` is high.

## Structure
- **Package `calc_pkg`:** state encodings ENTER_A/ENTER_B/READY, `OPERAND_W` = 14, `NUM_DIGITS` = 4, and a BCD-to-binary function. The ALU and display driver share these.
- **Sub-module `btn_debounce`:** synchroniser, counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES. Instantiated five times.
- **Top of `operand_entry`:** priority encoder, digit/cursor registers, state FSM and operand registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 8.
- **Entry sequence:** presses U, L, U, C, then L, U, C → `operand_a` = 11, `operand_b` = 10, `operands_valid` = 1, `entry_state` = 2, `digits` = 16'h0000.
- **Wrap-around:** 10×U → digit0 returns to 0. D from 0 → 9. R from cursor 0 → cursor 3. Then U → `digits` = 16'h1009.
- **Bounce:** a 5-cycle high pulse on `btnU` plus 3 alternating 2-cycle toggles before a clean hold → exactly one increment. The event pulse lands DEBOUNCE_CYCLES+2 edges after the final rise.
- **Simultaneous press:** U and L debounced on the same cycle → digit increments, cursor unchanged. C and D together → commit only.
- **Reset mid-entry:** `rst` pulsed for 1 ns while in ENTER_B with digits 16'h0042 → all outputs 0 immediately, `entry_state` = 0.
- **READY behaviour:** with state READY, U/D/L/R ignored; C → ENTER_A, `operands_valid` falls, `operand_a` and `operand_b` retained.
